// File: rtl/monta_numero_if.sv
// Keypad/UC operand-entry bundle for monta_numero.
// Carries keyed digits in and the assembled value plus live echo out.
interface monta_numero_if #(
  parameter int LARGURA = 32
);
  logic               estagioEntradaUC;
  logic [3:0]         digito;
  logic               digitoValido;
  logic               sinal;
  logic               confirma;
  logic [LARGURA-1:0] saida;
  logic               pronto;
  logic               erro;
  logic               indicaNegativo;
  logic [3:0]         centena;
  logic [3:0]         dezena;
  logic [3:0]         unidade;

  modport master (
    output estagioEntradaUC, digito, digitoValido,
    output sinal, confirma,
    input  saida, pronto, erro, indicaNegativo,
    input  centena, dezena, unidade
  );

  modport slave (
    input  estagioEntradaUC, digito, digitoValido,
    input  sinal, confirma,
    output saida, pronto, erro, indicaNegativo,
    output centena, dezena, unidade
  );
endinterface

// File: rtl/monta_numero.sv
// Assembles a signed decimal operand (-999..999) from keyed BCD digits
// and a sign toggle, converting serially via Horner into two's complement.
module monta_numero #(
  parameter int LARGURA = 32
) (
  input  logic           clock,
  input  logic           reset,
  monta_numero_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO,
    CAPTURA,
    CONVERTE,
    PRONTO
  } estado_t;

  localparam logic [LARGURA-1:0] UM = 1;

  estado_t            estado;
  estado_t            prox;
  logic [1:0]         cont;
  logic [1:0]         passo;
  logic [LARGURA-1:0] acc;
  logic [3:0]         dig_passo;
  logic               ativo;
  logic               aceita;
  logic               invalido;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO: begin
        if (bus.estagioEntradaUC) prox = CAPTURA;
      end
      CAPTURA: begin
        if (!bus.estagioEntradaUC) prox = OCIOSO;
        else if (bus.confirma)     prox = CONVERTE;
      end
      CONVERTE: begin
        if (passo == 2'd2) prox = PRONTO;
      end
      PRONTO: prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // confirma wins over digit and sign; leaving the input stage wins over all
  assign ativo = (estado == CAPTURA) && bus.estagioEntradaUC
              && !bus.confirma;
  assign aceita = ativo && bus.digitoValido
               && (bus.digito <= 4'd9) && (cont != 2'd3);
  assign invalido = ativo && bus.digitoValido
                 && (bus.digito > 4'd9);

  always_comb begin
    case (passo)
      2'd0:    dig_passo = bus.centena;
      2'd1:    dig_passo = bus.dezena;
      default: dig_passo = bus.unidade;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.saida          <= '0;
      bus.pronto         <= 1'b0;
      bus.erro           <= 1'b0;
      bus.indicaNegativo <= 1'b0;
      bus.centena        <= 4'd0;
      bus.dezena         <= 4'd0;
      bus.unidade        <= 4'd0;
      cont               <= 2'd0;
      passo              <= 2'd0;
      acc                <= '0;
    end else begin
      bus.pronto <= 1'b0;
      bus.erro   <= invalido;
      case (estado)
        OCIOSO: begin
          if (bus.estagioEntradaUC) begin
            bus.centena        <= 4'd0;
            bus.dezena         <= 4'd0;
            bus.unidade        <= 4'd0;
            bus.indicaNegativo <= 1'b0;
            cont               <= 2'd0;
          end
        end
        CAPTURA: begin
          if (aceita) begin
            bus.centena <= bus.dezena;
            bus.dezena  <= bus.unidade;
            bus.unidade <= bus.digito;
            cont        <= cont + 2'd1;
          end
          if (ativo && bus.sinal)
            bus.indicaNegativo <= ~bus.indicaNegativo;
          if (bus.estagioEntradaUC && bus.confirma) begin
            acc   <= '0;
            passo <= 2'd0;
          end
        end
        CONVERTE: begin
          // acc*10 + digit without a multiplier
          acc <= (acc << 3) + (acc << 1)
               + {{(LARGURA-4){1'b0}}, dig_passo};
          passo <= passo + 2'd1;
        end
        PRONTO: begin
          bus.saida  <= (bus.indicaNegativo && (acc != '0))
                      ? (~acc + UM) : acc;
          bus.pronto <= 1'b1;
          if (acc == '0) bus.indicaNegativo <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_monta_numero.sv
// Directed bench for monta_numero: entry, sign, rejection,
// abort and mid-conversion reset scenarios.
module tb_monta_numero;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  monta_numero_if #(.LARGURA(32)) bus ();

  monta_numero #(.LARGURA(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tecla(logic [3:0] d);
    bus.digito       = d;
    bus.digitoValido = 1'b1;
    tick();
    bus.digitoValido = 1'b0;
  endtask

  task automatic troca_sinal();
    bus.sinal = 1'b1;
    tick();
    bus.sinal = 1'b0;
  endtask

  task automatic confirmar();
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
  endtask

  // edges after the confirma edge until pronto; 0 means timeout
  task automatic espera_pronto(output int k);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.pronto) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    bus.estagioEntradaUC = 1'b0;
    bus.digito           = 4'd0;
    bus.digitoValido     = 1'b0;
    bus.sinal            = 1'b0;
    bus.confirma         = 1'b0;
    #12;
    chk("rst_saida", bus.saida, 32'h0);
    chk("rst_pronto", {31'd0, bus.pronto}, 32'd0);
    chk("rst_erro", {31'd0, bus.erro}, 32'd0);
    chk("rst_neg", {31'd0, bus.indicaNegativo}, 32'd0);
    reset = 1'b0;
    tick();

    // 123
    bus.estagioEntradaUC = 1'b1;
    tick();
    tecla(4'd1); tecla(4'd2); tecla(4'd3);
    chk("echo_uni", {28'd0, bus.unidade}, 32'd3);
    confirmar();
    chk("pronto_early", {31'd0, bus.pronto}, 32'd0);
    espera_pronto(n);
    chk("lat_123", n, 32'd4);
    chk("saida_123", bus.saida, 32'h0000007B);
    chk("neg_123", {31'd0, bus.indicaNegativo}, 32'd0);
    chk("echo_123", {20'd0, bus.centena, bus.dezena, bus.unidade},
        32'h123);
    tick();
    chk("pronto_drop", {31'd0, bus.pronto}, 32'd0);
    tick();

    // -45
    tecla(4'd4); tecla(4'd5);
    troca_sinal();
    chk("neg_live", {31'd0, bus.indicaNegativo}, 32'd1);
    confirmar();
    espera_pronto(n);
    chk("lat_m45", n, 32'd4);
    chk("saida_m45", bus.saida, 32'hFFFFFFD3);
    chk("neg_m45", {31'd0, bus.indicaNegativo}, 32'd1);
    tick();
    chk("hold_m45", bus.saida, 32'hFFFFFFD3);
    tick();

    // 9,8,7, 6 ignored, 0xC rejected
    tecla(4'd9); tecla(4'd8); tecla(4'd7);
    tecla(4'd6);
    chk("erro_full", {31'd0, bus.erro}, 32'd0);
    tecla(4'hC);
    chk("erro_pulse", {31'd0, bus.erro}, 32'd1);
    chk("echo_987", {20'd0, bus.centena, bus.dezena, bus.unidade},
        32'h987);
    confirmar();
    chk("erro_drop", {31'd0, bus.erro}, 32'd0);
    espera_pronto(n);
    chk("lat_987", n, 32'd4);
    chk("saida_987", bus.saida, 32'h000003DB);
    tick(); tick();

    // three sign toggles, no digits, confirma with a digit
    troca_sinal(); troca_sinal(); troca_sinal();
    chk("neg_odd", {31'd0, bus.indicaNegativo}, 32'd1);
    bus.digito       = 4'd5;
    bus.digitoValido = 1'b1;
    confirmar();
    bus.digitoValido = 1'b0;
    espera_pronto(n);
    chk("lat_zero", n, 32'd4);
    chk("saida_zero", bus.saida, 32'h0);
    chk("neg_zero", {31'd0, bus.indicaNegativo}, 32'd0);
    chk("uni_zero", {28'd0, bus.unidade}, 32'd0);
    tick(); tick();

    // 3, so the abort below has a non-zero value to keep
    tecla(4'd3);
    confirmar();
    espera_pronto(n);
    chk("saida_3", bus.saida, 32'h3);
    tick(); tick();

    // 5,5 then abort
    tecla(4'd5); tecla(4'd5);
    chk("echo_55", {24'd0, bus.dezena, bus.unidade}, 32'h55);
    bus.estagioEntradaUC = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.pronto) n++;
    end
    chk("abort_pronto", n, 32'd0);
    chk("abort_hold", bus.saida, 32'h3);
    bus.estagioEntradaUC = 1'b1;
    tick();
    confirmar();
    espera_pronto(n);
    chk("lat_reentry", n, 32'd4);
    chk("saida_reentry", bus.saida, 32'h0);
    tick(); tick();

    // reset during the second conversion step
    tecla(4'd2); tecla(4'd1);
    troca_sinal();
    confirmar();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_saida", bus.saida, 32'h0);
    chk("mid_echo", {20'd0, bus.centena, bus.dezena, bus.unidade},
        32'h0);
    chk("mid_neg", {31'd0, bus.indicaNegativo}, 32'd0);
    chk("mid_pronto", {31'd0, bus.pronto}, 32'd0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.pronto) n++;
      tick();
    end
    chk("post_rst_pronto", n, 32'd0);
    tecla(4'd7);
    confirmar();
    espera_pronto(n);
    chk("lat_7", n, 32'd4);
    chk("saida_7", bus.saida, 32'h00000007);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
